// File: rtl/freq_pkg.sv
// Shared constants, FSM state type and saturation helpers
// for the frequency / duty calculation path.
package freq_pkg;

    localparam int DW         = 48;
    localparam int DUTY_SCALE = 1000;
    localparam int DIV_STEPS  = DW;

    localparam logic [31:0] FREQ_SAT = 32'hFFFF_FFFF;
    localparam logic [9:0]  DUTY_SAT = 10'd1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV_FREQ,
        ST_DIV_DUTY,
        ST_DONE
    } state_t;

    function automatic logic [31:0] sat_freq(
        input logic [DW-1:0] q
    );
        if (q[DW-1:32] != '0) begin
            return FREQ_SAT;
        end
        return q[31:0];
    endfunction

    function automatic logic [9:0] sat_duty(
        input logic [DW-1:0] q,
        input logic          zero_div
    );
        if (zero_div) begin
            return 10'd0;
        end
        if (q > DW'(DUTY_SAT)) begin
            return DUTY_SAT;
        end
        return q[9:0];
    endfunction

endpackage

// File: rtl/freq_duty_calc_if.sv
// Measurement-in / result-out bundle between the capture
// stage and the display path.
interface freq_duty_calc_if;

    logic        meas_valid;
    logic [31:0] high_time;
    logic [31:0] low_time;
    logic [31:0] period_time;
    logic [31:0] freq_hz;
    logic [9:0]  duty_permille;
    logic        result_valid;
    logic        no_signal;
    logic        busy;
    logic        overrun;

    modport master (
        output meas_valid,
        output high_time,
        output low_time,
        output period_time,
        input  freq_hz,
        input  duty_permille,
        input  result_valid,
        input  no_signal,
        input  busy,
        input  overrun
    );

    modport slave (
        input  meas_valid,
        input  high_time,
        input  low_time,
        input  period_time,
        output freq_hz,
        output duty_permille,
        output result_valid,
        output no_signal,
        output busy,
        output overrun
    );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one load cycle, then one
// quotient bit per cycle. Divide by zero yields all ones.
module seq_divider #(
    parameter int DW = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [DW-1:0] i_dividend,
    input  logic [DW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_quot,
    output logic [DW-1:0] o_rem
);

    localparam int CNT_W = $clog2(DW + 1);

    logic [DW-1:0]    r_rem;
    logic [DW-1:0]    r_quo;
    logic [DW-1:0]    r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [DW:0]      w_sh;
    logic [DW+1:0]    w_diff;
    logic             w_neg;

    // Dividend bits stream out of the quotient MSB while
    // quotient bits stream in at the LSB.
    assign w_sh   = {r_rem, r_quo[DW-1]};
    assign w_diff = {1'b0, w_sh} - {2'b00, r_dvs};
    assign w_neg  = w_diff[DW+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (!r_busy) begin
                if (i_start) begin
                    r_rem  <= '0;
                    r_quo  <= i_dividend;
                    r_dvs  <= i_divisor;
                    r_cnt  <= CNT_W'(DW);
                    r_busy <= 1'b1;
                end
            end else begin
                r_quo <= {r_quo[DW-2:0], !w_neg};
                r_rem <= w_neg ? w_sh[DW-1:0]
                               : w_diff[DW-1:0];
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_quot = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/freq_duty_calc.sv
// Averages a window of captured periods and derives
// frequency (Hz) and duty (permille), with loss-of-signal.
import freq_pkg::*;

module freq_duty_calc #(
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int unsigned AVG_LOG2       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input logic             clk,
    input logic             rst,
    freq_duty_calc_if.slave s
);

    localparam int SW = 32 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    localparam logic [CW-1:0] LAST =
        CW'((1 << AVG_LOG2) - 1);
    localparam logic [DW-1:0] FREQ_NUM =
        DW'(64'(CLOCK_FREQ) << AVG_LOG2);
    localparam logic [31:0] TO_LAST =
        32'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] STEP_LAST = 6'(DIV_STEPS);

    logic [SW-1:0] r_sum_p;
    logic [SW-1:0] r_sum_h;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_op_p;
    logic [SW-1:0] r_op_h;
    logic [31:0]   r_idle;
    state_t        r_state;
    logic [5:0]    r_step;
    logic [DW-1:0] r_freq_q;
    logic [31:0]   r_freq;
    logic [9:0]    r_duty;
    logic          r_rv;
    logic          r_nosig;
    logic          r_ovr;

    logic [SW-1:0] w_sum_p;
    logic [SW-1:0] w_sum_h;
    logic          w_win;
    logic          w_to;
    logic          w_in_div;
    logic          w_div_start;
    logic          w_div_busy;
    logic          w_div_done;
    logic [DW-1:0] w_dvd;
    logic [DW-1:0] w_dvs;
    logic [DW-1:0] w_duty_num;
    logic [DW-1:0] w_quo;
    logic [DW-1:0] w_div_rem_unused;
    logic          w_low_unused;

    assign w_low_unused = ^s.low_time;

    assign w_sum_p = r_sum_p + SW'(s.period_time);
    assign w_sum_h = r_sum_h + SW'(s.high_time);
    assign w_win   = s.meas_valid && (r_cnt == LAST);
    // A strobe in the expiry cycle wins over the timeout.
    assign w_to    = !s.meas_valid && (r_idle == TO_LAST);

    assign w_in_div = (r_state == ST_DIV_FREQ) ||
                      (r_state == ST_DIV_DUTY);
    assign w_div_start = w_in_div && (r_step == '0) &&
                         !w_div_busy;
    assign w_duty_num  = DW'(r_op_h) * DW'(DUTY_SCALE);
    assign w_dvd = (r_state == ST_DIV_DUTY) ? w_duty_num
                                            : FREQ_NUM;
    assign w_dvs = DW'(r_op_p);

    seq_divider #(
        .DW(DW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_abort    (w_to),
        .i_dividend (w_dvd),
        .i_divisor  (w_dvs),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_quo),
        .o_rem      (w_div_rem_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_p <= '0;
            r_sum_h <= '0;
            r_cnt   <= '0;
            r_op_p  <= '0;
            r_op_h  <= '0;
            r_idle  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (s.meas_valid) begin
                r_idle <= '0;
            end else if (r_idle != '1) begin
                r_idle <= r_idle + 1'b1;
            end
            if (w_to) begin
                r_sum_p <= '0;
                r_sum_h <= '0;
                r_cnt   <= '0;
            end else if (w_win) begin
                r_sum_p <= '0;
                r_sum_h <= '0;
                r_cnt   <= '0;
                if (r_state == ST_IDLE) begin
                    r_op_p <= w_sum_p;
                    r_op_h <= w_sum_h;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (s.meas_valid) begin
                r_sum_p <= w_sum_p;
                r_sum_h <= w_sum_h;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_step   <= '0;
            r_freq_q <= '0;
            r_freq   <= '0;
            r_duty   <= '0;
            r_rv     <= 1'b0;
            r_nosig  <= 1'b0;
        end else begin
            r_rv <= 1'b0;
            if (s.meas_valid) begin
                r_nosig <= 1'b0;
            end
            if (w_to) begin
                r_state <= ST_IDLE;
                r_step  <= '0;
                r_freq  <= '0;
                r_duty  <= '0;
                r_nosig <= 1'b1;
                r_rv    <= 1'b1;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_win) begin
                            r_state <= ST_DIV_FREQ;
                            r_step  <= '0;
                        end
                    end
                    ST_DIV_FREQ: begin
                        if (r_step == STEP_LAST) begin
                            r_state <= ST_DIV_DUTY;
                            r_step  <= '0;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                    ST_DIV_DUTY: begin
                        if (w_div_done) begin
                            r_freq_q <= w_quo;
                        end
                        if (r_step == STEP_LAST) begin
                            r_state <= ST_DONE;
                            r_step  <= '0;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_freq  <= sat_freq(r_freq_q);
                        r_duty  <= sat_duty(w_quo,
                                            r_op_p == '0);
                        r_rv    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign s.freq_hz       = r_freq;
    assign s.duty_permille = r_duty;
    assign s.result_valid  = r_rv;
    assign s.no_signal     = r_nosig;
    assign s.busy          = (r_state != ST_IDLE);
    assign s.overrun       = r_ovr;

endmodule

// File: tb/tb_freq_duty_calc.sv
// Directed bench: window averaging, saturation, timeout,
// overrun and mid-division reset.
module tb_freq_duty_calc;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    freq_duty_calc_if ifa ();
    freq_duty_calc_if ifb ();

    freq_duty_calc #(
        .CLOCK_FREQ     (50000000),
        .AVG_LOG2       (2),
        .TIMEOUT_CYCLES (1000)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .s   (ifa)
    );

    freq_duty_calc #(
        .CLOCK_FREQ     (50000000),
        .AVG_LOG2       (0),
        .TIMEOUT_CYCLES (100000)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .s   (ifb)
    );

    int nvec = 0;
    int nerr = 0;
    int rv_a = 0;
    int rv_b = 0;
    int ov_b = 0;
    int base;

    always @(posedge clk) begin
        if (ifa.result_valid) rv_a++;
        if (ifb.result_valid) rv_b++;
        if (ifb.overrun) ov_b++;
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] p,
                          input logic [31:0] h);
        ifa.meas_valid  = 1'b1;
        ifa.period_time = p;
        ifa.high_time   = h;
        ifa.low_time    = p - h;
        tick();
        ifa.meas_valid  = 1'b0;
    endtask

    task automatic wait_rv_a(input string tag);
        int n = 0;
        while (!ifa.result_valid && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(ifa.result_valid), 64'd1);
    endtask

    initial begin
        ifa.meas_valid  = 1'b0;
        ifa.period_time = '0;
        ifa.high_time   = '0;
        ifa.low_time    = '0;
        ifb.meas_valid  = 1'b0;
        ifb.period_time = '0;
        ifb.high_time   = '0;
        ifb.low_time    = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        chk("rst_freq", 64'(ifa.freq_hz), 64'd0);
        chk("rst_duty", 64'(ifa.duty_permille), 64'd0);
        chk("rst_rv", 64'(ifa.result_valid), 64'd0);
        chk("rst_nosig", 64'(ifa.no_signal), 64'd0);
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_ovr", 64'(ifa.overrun), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // 1 kHz, 25 %, with exact latency
        base = rv_a;
        send_a(50000, 12500);
        send_a(50000, 12500);
        send_a(50000, 12500);
        send_a(50000, 12500);
        chk("t1_busy", 64'(ifa.busy), 64'd1);
        repeat (98) tick();
        chk("t1_rv_early", 64'(ifa.result_valid), 64'd0);
        tick();
        chk("t1_rv", 64'(ifa.result_valid), 64'd1);
        chk("t1_freq", 64'(ifa.freq_hz), 64'd1000);
        chk("t1_duty", 64'(ifa.duty_permille), 64'd250);
        tick();
        chk("t1_rv_off", 64'(ifa.result_valid), 64'd0);
        chk("t1_idle", 64'(ifa.busy), 64'd0);
        chk("t1_rv_cnt", 64'(rv_a - base), 64'd1);

        // period 3, high 1
        send_a(3, 1);
        send_a(3, 1);
        send_a(3, 1);
        send_a(3, 1);
        wait_rv_a("t2_rv");
        chk("t2_freq", 64'(ifa.freq_hz), 64'd16666666);
        chk("t2_duty", 64'(ifa.duty_permille), 64'd333);
        tick();

        // mixed periods
        send_a(1000, 500);
        send_a(1000, 500);
        send_a(1000, 500);
        send_a(1001, 500);
        wait_rv_a("t3_rv");
        chk("t3_freq", 64'(ifa.freq_hz), 64'd49987);
        chk("t3_duty", 64'(ifa.duty_permille), 64'd499);
        tick();

        // zero divisor
        send_a(0, 0);
        send_a(0, 0);
        send_a(0, 0);
        send_a(0, 0);
        wait_rv_a("t4_rv");
        chk("t4_freq", 64'(ifa.freq_hz), 64'hFFFF_FFFF);
        chk("t4_duty", 64'(ifa.duty_permille), 64'd0);
        tick();

        // timeout after a partial window
        send_a(7777, 1111);
        base = rv_a;
        repeat (999) tick();
        chk("to_early", 64'(ifa.no_signal), 64'd0);
        tick();
        chk("to_nosig", 64'(ifa.no_signal), 64'd1);
        chk("to_rv", 64'(ifa.result_valid), 64'd1);
        chk("to_freq", 64'(ifa.freq_hz), 64'd0);
        chk("to_duty", 64'(ifa.duty_permille), 64'd0);
        tick();
        chk("to_rv_cnt", 64'(rv_a - base), 64'd1);
        chk("to_nosig_hold", 64'(ifa.no_signal), 64'd1);
        send_a(50000, 12500);
        chk("rc_nosig", 64'(ifa.no_signal), 64'd0);
        chk("rc_rv", 64'(ifa.result_valid), 64'd0);
        chk("rc_freq", 64'(ifa.freq_hz), 64'd0);
        send_a(50000, 12500);
        send_a(50000, 12500);
        chk("rc_not_busy", 64'(ifa.busy), 64'd0);
        send_a(50000, 12500);
        chk("rc_rv_cnt", 64'(rv_a - base), 64'd1);
        wait_rv_a("rc_rv2");
        chk("rc_freq2", 64'(ifa.freq_hz), 64'd1000);
        chk("rc_duty2", 64'(ifa.duty_permille), 64'd250);

        // AVG_LOG2=0, strobe every cycle
        base = rv_b;
        ifb.meas_valid  = 1'b1;
        ifb.period_time = 50000;
        ifb.high_time   = 25000;
        ifb.low_time    = 25000;
        tick();
        chk("b_busy", 64'(ifb.busy), 64'd1);
        chk("b_ovr0", 64'(ifb.overrun), 64'd0);
        tick();
        chk("b_ovr1", 64'(ifb.overrun), 64'd1);
        repeat (98) tick();
        chk("b_rv", 64'(ifb.result_valid), 64'd1);
        chk("b_freq", 64'(ifb.freq_hz), 64'd1000);
        chk("b_duty", 64'(ifb.duty_permille), 64'd500);
        tick();
        chk("b_ovr_cnt", 64'(ov_b), 64'd99);
        chk("b_busy2", 64'(ifb.busy), 64'd1);
        repeat (55) tick();
        rst_b = 1'b1;
        ifb.meas_valid = 1'b0;
        #1;
        chk("br_freq", 64'(ifb.freq_hz), 64'd0);
        chk("br_duty", 64'(ifb.duty_permille), 64'd0);
        chk("br_busy", 64'(ifb.busy), 64'd0);
        chk("br_ovr", 64'(ifb.overrun), 64'd0);
        chk("br_nosig", 64'(ifb.no_signal), 64'd0);
        tick();
        tick();
        rst_b = 1'b0;
        repeat (150) tick();
        chk("br_rv_cnt", 64'(rv_b - base), 64'd1);
        chk("br_freq2", 64'(ifb.freq_hz), 64'd0);
        chk("br_busy2", 64'(ifb.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule

// File: doc/freq_duty_calc.md
Name: freq_duty_calc

Overview:
- Downstream consumer of the input-capture stage: accepts per-cycle high/low/period counts plus a one-cycle done strobe.
- Averages 2^AVG_LOG2 consecutive periods.
- Computes frequency in Hz and duty cycle in permille using one shared sequential restoring divider.
- Flags loss of signal after a timeout; results feed the display/report path.

Parameters:
- CLOCK_FREQ, 50000000, system clock in Hz; CLOCK_FREQ*2^AVG_LOG2 must be < 2^48.
- AVG_LOG2, 3, log2 of the number of periods averaged per result (0..8).
- TIMEOUT_CYCLES, 50000000, clk cycles without meas_valid before no_signal is declared.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- meas_valid  in  1  one-cycle strobe; high_time/period_time are valid in the same cycle
- high_time  in  32  high duration in clk cycles
- low_time  in  32  low duration; unused in computation, kept for interface symmetry
- period_time  in  32  period in clk cycles
- freq_hz  out  32  averaged frequency, Hz, truncated
- duty_permille  out  10  averaged duty, 0..1000, truncated
- result_valid  out  1  one-cycle pulse when freq_hz/duty_permille/no_signal update
- no_signal  out  1  high while the timeout is active
- busy  out  1  divider FSM not in IDLE
- overrun  out  1  one-cycle pulse when a completed window is dropped

Behaviour:
- Reset: every output 0, all accumulators/counters 0, FSM IDLE. Reset asserted mid-division aborts it; no result_valid is produced.
- Accumulation (independent of FSM):
  - On meas_valid: sum_period += period_time and sum_high += high_time (32+AVG_LOG2 bits each, no overflow possible); sample_cnt++.
  - When sample_cnt reaches 2^AVG_LOG2 on that edge:
    - If FSM is IDLE: the final sums (including the current sample) are snapshotted into operand registers.
    - Otherwise: the window is discarded and overrun pulses.
    - In both cases accumulators and sample_cnt clear.
- FSM states: IDLE, DIV_FREQ, DIV_DUTY, DONE.
  - IDLE -> DIV_FREQ on snapshot.
  - DIV_FREQ:
    - Dividend = CLOCK_FREQ<<AVG_LOG2; divisor = sum_period. Both zero-extended to DW=48 bits.
    - 1 load cycle + 48 iteration cycles, then -> DIV_DUTY.
  - DIV_DUTY:
    - Dividend = 1000*sum_high (48 bits); divisor = sum_period.
    - Same 49 cycles, then -> DONE.
  - DONE: register outputs, pulse result_valid, -> IDLE.
- Latency: result_valid is high in the cycle following the 99th rising edge after the edge that sampled the window-completing meas_valid.
- Saturation and limits:
  - freq quotient > 2^32-1 -> freq_hz = 32'hFFFF_FFFF.
  - duty quotient > 1000 -> 1000.
  - Divisor 0 -> freq_hz = 32'hFFFF_FFFF, duty_permille = 0.
- Timeout:
  - idle_cnt clears on every meas_valid and otherwise increments, saturating.
  - When idle_cnt reaches TIMEOUT_CYCLES:
    - no_signal = 1; freq_hz and duty_permille = 0.
    - Accumulators clear; any in-flight division is aborted and FSM -> IDLE.
    - result_valid pulses exactly once.
  - The first subsequent meas_valid clears no_signal, with no result_valid. Values stay 0 until the next completed window.
- Simultaneous events:
  - meas_valid in the same cycle as timeout expiry: meas_valid wins (idle_cnt clears, no timeout).
  - meas_valid arriving in the DONE cycle is accumulated normally.

Decomposition:
- Shared package freq_pkg: DW=48, DUTY_SCALE=1000, FSM state enum, saturation constants.
- Sub-module seq_divider (unsigned restoring division, DW-bit operands).
  - start/busy/done handshake: start is accepted only when not busy; done pulses one cycle.
  - Outputs quotient and remainder; divide-by-zero returns all-ones quotient.
  - Synchronous abort input.

Test Plan:
- AVG_LOG2=2, four meas_valid with period=50000, high=12500 -> result_valid once; freq_hz=1000, duty_permille=250; latency exactly 99 edges after the 4th strobe.
- AVG_LOG2=2, four samples period=3, high=1 -> freq_hz=16666666, duty_permille=333.
- Mixed window: periods 1000,1000,1000,1001 with high=500 each -> freq_hz=49987 (200e6/4001), duty_permille=499.
- period_time=0, high=0 for a full window -> freq_hz=32'hFFFF_FFFF, duty_permille=0.
- TIMEOUT_CYCLES=1000, strobes stop -> at cycle 1000: no_signal=1, freq_hz=0, one result_valid. Next strobe clears no_signal with no result_valid.
- AVG_LOG2=0, meas_valid every cycle -> first window computed; windows completing while busy pulse overrun; reset asserted during DIV_DUTY leaves all outputs 0 and produces no result_valid.
